icache_direct: RTL

Direct-mapped, read-only instruction cache between the core's instruction bus (`ibus_req_t`/`ibus_resp_t`) and the cache-line bus (`cbus_req_t`/`cbus_resp_t`) that feeds the memory arbiter. Hits return in the request cycle. Misses refill one whole line with a single cbus burst, then replay as a hit. A `flush` input supports `fence.i`.

---
 rtl/icache_direct_pkg.sv | 52 +++++
 rtl/icache_direct_meta.sv | 42 ++++
 rtl/icache_direct.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/icache_direct_pkg.sv
// Shared bus types for the instruction cache.
//   ibus_req_t / ibus_resp_t : core fetch port (valid+addr in, addr_ok/data_ok/data out)
//   cbus_req_t / cbus_resp_t : cache-line bus towards the memory arbiter
//   MSIZE8, AXI_BURST_INCR   : transfer size / burst encodings used by refills
package icache_direct_pkg;

    typedef enum logic [2:0] {
        MSIZE1 = 3'b000,
        MSIZE2 = 3'b001,
        MSIZE4 = 3'b010,
        MSIZE8 = 3'b011
    } msize_t;

    typedef enum logic [1:0] {
        AXI_BURST_FIXED = 2'b00,
        AXI_BURST_INCR  = 2'b01,
        AXI_BURST_WRAP  = 2'b10
    } axi_burst_type_t;

    typedef logic [63:0] addr_t;
    typedef logic [3:0]  mlen_t;
    typedef logic [7:0]  strobe_t;

    typedef struct packed {
        logic  valid;
        addr_t addr;
    } ibus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [31:0] data;
    } ibus_resp_t;

    typedef struct packed {
        logic            valid;
        logic            is_write;
        msize_t          size;
        addr_t           addr;
        strobe_t         strobe;
        logic [63:0]     data;
        mlen_t           len;
        axi_burst_type_t burst;
    } cbus_req_t;

    typedef struct packed {
        logic        ready;
        logic        last;
        logic [63:0] data;
    } cbus_resp_t;

endpackage

// File: rtl/icache_direct_meta.sv
// Valid/tag array for the direct-mapped icache.
//   clk, reset   : clock, synchronous active-high reset (clears valid bits only)
//   clear_all    : invalidate every line at the clock edge; wins over wr_en
//   rd_index     : combinational lookup index -> rd_valid, rd_tag
//   wr_en/index/tag : mark a line valid with the given tag
module icache_meta #(
    parameter int SETS     = 16,
    parameter int TAG_BITS = 54
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clear_all,
    input  logic [$clog2(SETS)-1:0] rd_index,
    output logic                    rd_valid,
    output logic [TAG_BITS-1:0]     rd_tag,
    input  logic                    wr_en,
    input  logic [$clog2(SETS)-1:0] wr_index,
    input  logic [TAG_BITS-1:0]     wr_tag
);

    logic [SETS-1:0]     valid_q;
    logic [TAG_BITS-1:0] tag_q [SETS];

    always_ff @(posedge clk) begin
        if (reset || clear_all) begin
            valid_q <= '0;
        end else if (wr_en) begin
            valid_q[wr_index] <= 1'b1;
        end
    end

    // Tags are qualified by valid, so they need no reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_q[wr_index] <= wr_tag;
        end
    end

    assign rd_valid = valid_q[rd_index];
    assign rd_tag   = tag_q[rd_index];

endmodule

// File: rtl/icache_direct.sv
// Direct-mapped read-only instruction cache.
//   clk, reset : clock, synchronous active-high reset
//   ireq       : fetch request from the core (held stable until data_ok)
//   iresp      : addr_ok/data_ok/data; hits answer in the request cycle
//   creq/cresp : one INCR burst of LINE_WORDS x 64-bit beats per miss
//   flush      : one-cycle pulse invalidating every line (fence.i)
//   dbg_state  : current FSM state (0 IDLE, 1 REFILL, 2 DONE)
// LINE_WORDS must be a power of two between 2 and 16; SETS a power of two >= 2.
//
// cbus handshake: creq is valid and constant for the whole refill; a beat
// transfers on every cycle cresp.ready is high while creq.valid is high, and
// cresp.last marks the final beat of the burst.
module icache_direct
    import icache_direct_pkg::*;
#(
    parameter int SETS       = 16,
    parameter int LINE_WORDS = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  ibus_req_t  ireq,
    output ibus_resp_t iresp,
    output cbus_req_t  creq,
    input  cbus_resp_t cresp,
    input  logic       flush,
    output logic [1:0] dbg_state
);

    localparam int WORD_BITS   = $clog2(LINE_WORDS);
    localparam int OFFSET_BITS = WORD_BITS + 3;
    localparam int INDEX_BITS  = $clog2(SETS);
    localparam int TAG_BITS    = 64 - OFFSET_BITS - INDEX_BITS;
    localparam logic [WORD_BITS-1:0] LAST_WORD = WORD_BITS'(LINE_WORDS - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REFILL = 2'd1,
        DONE   = 2'd2
    } icache_state_t;

    icache_state_t state_q, state_d;
    logic [WORD_BITS-1:0]  cnt_q;
    logic                  flush_pend_q;
    logic [TAG_BITS-1:0]   fill_tag_q;
    logic [INDEX_BITS-1:0] fill_index_q;
    logic [63:0]           data_q [SETS][LINE_WORDS];

    logic [TAG_BITS-1:0]   req_tag;
    logic [INDEX_BITS-1:0] req_index;
    logic [WORD_BITS-1:0]  req_word;
    logic                  req_half;
    logic                  hit_valid, hit, beat, fill_done, clear_all, miss_start;
    logic [TAG_BITS-1:0]   hit_tag;
    logic [63:0]           hit_word;
    logic                  unused_addr_bits;

    assign req_tag   = ireq.addr[63 -: TAG_BITS];
    assign req_index = ireq.addr[OFFSET_BITS +: INDEX_BITS];
    assign req_word  = ireq.addr[3 +: WORD_BITS];
    assign req_half  = ireq.addr[2];
    assign unused_addr_bits = ^ireq.addr[1:0];

    assign hit        = hit_valid && (hit_tag == req_tag);
    assign hit_word   = data_q[req_index][req_word];
    assign miss_start = !reset && (state_q == IDLE) && ireq.valid && !hit;
    assign beat       = !reset && (state_q == REFILL) && cresp.ready;
    assign fill_done  = beat && cresp.last;
    assign dbg_state  = state_q;

    icache_meta #(
        .SETS     (SETS),
        .TAG_BITS (TAG_BITS)
    ) u_meta (
        .clk       (clk),
        .reset     (reset),
        .clear_all (clear_all),
        .rd_index  (req_index),
        .rd_valid  (hit_valid),
        .rd_tag    (hit_tag),
        .wr_en     (fill_done),
        .wr_index  (fill_index_q),
        .wr_tag    (fill_tag_q)
    );

    always_comb begin
        state_d   = state_q;
        iresp     = '0;
        creq      = '0;
        clear_all = 1'b0;
        unique case (state_q)
            IDLE: begin
                // A same-cycle hit reads pre-flush contents; the clear lands at the edge.
                clear_all = flush;
                if (ireq.valid) begin
                    if (hit) begin
                        iresp.addr_ok = 1'b1;
                        iresp.data_ok = 1'b1;
                        iresp.data    = req_half ? hit_word[63:32] : hit_word[31:0];
                    end else begin
                        state_d = REFILL;
                    end
                end
            end
            REFILL: begin
                creq.valid    = 1'b1;
                creq.is_write = 1'b0;
                creq.size     = MSIZE8;
                creq.burst    = AXI_BURST_INCR;
                creq.len      = mlen_t'(LINE_WORDS - 1);
                creq.addr     = {fill_tag_q, fill_index_q, {OFFSET_BITS{1'b0}}};
                if (fill_done) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                // Deferred flush applies here, after the refilled line was validated.
                clear_all = flush_pend_q || flush;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (reset) begin
            iresp     = '0;
            creq      = '0;
            clear_all = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            flush_pend_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (miss_start) begin
                cnt_q <= '0;
            end else if (beat) begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (state_q == REFILL && flush) begin
                flush_pend_q <= 1'b1;
            end else if (state_q == DONE) begin
                flush_pend_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (miss_start) begin
            fill_tag_q   <= req_tag;
            fill_index_q <= req_index;
        end
    end

    always_ff @(posedge clk) begin
        if (beat) begin
            data_q[fill_index_q][cnt_q] <= cresp.data;
        end
    end

    // The burst must end exactly on the final word of the line.
    a_last_on_final_word: assert property (
        @(posedge clk) disable iff (reset)
        fill_done |-> (cnt_q == LAST_WORD)
    );

endmodule
